// File: rtl/rtype_pkg.sv
// Shared encodings for the R-type execute pipeline: major opcodes, funct3/funct7
// values and the ALU operation enum used by decode and by rtype_alu.
package rtype_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
  } alu_op_e;

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU. RV64 word operations (32-bit compute, sign-extended
// result) are compiled in only when RTYPE_WORD_OPS_EN is defined.
module rtype_alu
  import rtype_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // RV64 shifts use six shift-amount bits, RV32 five
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

`ifdef RTYPE_WORD_OPS_EN
  logic [31:0] wy;

  // 32-bit word-op result, sign-extended into y below
  always_comb begin
    wy = '0;
    case (op)
      ALU_ADDW: wy = a[31:0] + b[31:0];
      ALU_SUBW: wy = a[31:0] - b[31:0];
      ALU_SLLW: wy = a[31:0] << b[4:0];
      ALU_SRLW: wy = a[31:0] >> b[4:0];
      ALU_SRAW: wy = $signed(a[31:0]) >>> b[4:0];
      default:  wy = '0;
    endcase
  end
`endif

  // Main operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
`ifdef RTYPE_WORD_OPS_EN
      ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW: y = XLEN'($signed(wy));
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rtype_exec_pipe.sv
// Three-stage R-type execute pipeline: D (decode register), E (register read,
// W-stage bypass, ALU; combinational on D), W (result register, drives res_*).
// Optional macro RTYPE_WORD_OPS_EN enables opcode 0111011 word ops when XLEN=64;
// otherwise that opcode retires as illegal.
module rtype_exec_pipe
  import rtype_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_data,
  output logic            res_illegal
);

  localparam int AW = $clog2(NREGS);

  logic                        d_valid_q, d_valid_d;
  logic [31:0]                 d_instr_q, d_instr_d;
  logic                        w_valid_q, w_valid_d;
  logic                        w_ill_q, w_ill_d;
  logic [4:0]                  w_rd_q, w_rd_d;
  logic [XLEN-1:0]             w_data_q, w_data_d;
  logic [NREGS-1:0][XLEN-1:0]  rf_q, rf_d;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd;
  alu_op_e         e_op;
  logic            e_legal;
  logic [XLEN-1:0] e_a, e_b, e_y;
  logic            stall, rf_we;

  // A result waiting on the consumer freezes every stage
  assign stall       = w_valid_q && !res_ready;
  assign instr_ready = !d_valid_q || !stall;
  assign rf_we       = w_valid_q && res_ready && !w_ill_q && (w_rd_q != 5'd0);

  assign {f7, rs2, rs1, f3, rd, opc} = d_instr_q;

  assign res_valid   = w_valid_q;
  assign res_rd      = w_rd_q;
  assign res_data    = w_data_q;
  assign res_illegal = w_ill_q;

  // Decode the D-stage word into an ALU op and a legality flag
  always_comb begin
    e_op    = ALU_ADD;
    e_legal = 1'b0;
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE) begin
        e_legal = 1'b1;
        case (f3)
          F3_ADD_SUB: e_op = ALU_ADD;
          F3_SLL:     e_op = ALU_SLL;
          F3_SLT:     e_op = ALU_SLT;
          F3_SLTU:    e_op = ALU_SLTU;
          F3_XOR:     e_op = ALU_XOR;
          F3_SRL_SRA: e_op = ALU_SRL;
          F3_OR:      e_op = ALU_OR;
          default:    e_op = ALU_AND;
        endcase
      end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
        e_legal = 1'b1;
        e_op    = (f3 == F3_ADD_SUB) ? ALU_SUB : ALU_SRA;
      end
    end
    if (opc == OPC_OP32) begin
`ifdef RTYPE_WORD_OPS_EN
      if (XLEN == 64) begin
        if (f7 == F7_BASE && f3 == F3_ADD_SUB) begin e_legal = 1'b1; e_op = ALU_ADDW; end
        if (f7 == F7_BASE && f3 == F3_SLL)     begin e_legal = 1'b1; e_op = ALU_SLLW; end
        if (f7 == F7_BASE && f3 == F3_SRL_SRA) begin e_legal = 1'b1; e_op = ALU_SRLW; end
        if (f7 == F7_ALT  && f3 == F3_ADD_SUB) begin e_legal = 1'b1; e_op = ALU_SUBW; end
        if (f7 == F7_ALT  && f3 == F3_SRL_SRA) begin e_legal = 1'b1; e_op = ALU_SRAW; end
      end
`endif
    end
    // Destinations beyond the implemented register file are rejected
    if ((rd >> AW) != 5'd0) e_legal = 1'b0;
  end

  // Operand fetch: x0 and unimplemented indices read zero, W result overrides the file
  always_comb begin
    e_a = '0;
    e_b = '0;
    if (rs1 != 5'd0 && (rs1 >> AW) == 5'd0) e_a = rf_q[rs1[AW-1:0]];
    if (rs2 != 5'd0 && (rs2 >> AW) == 5'd0) e_b = rf_q[rs2[AW-1:0]];
    if (w_valid_q && !w_ill_q && w_rd_q != 5'd0 && w_rd_q == rs1) e_a = w_data_q;
    if (w_valid_q && !w_ill_q && w_rd_q != 5'd0 && w_rd_q == rs2) e_b = w_data_q;
  end

  rtype_alu #(.XLEN(XLEN)) u_alu (
    .op (e_op),
    .a  (e_a),
    .b  (e_b),
    .y  (e_y)
  );

  // Next-state for D, W and the register file
  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    w_valid_d = w_valid_q;
    w_ill_d   = w_ill_q;
    w_rd_d    = w_rd_q;
    w_data_d  = w_data_q;
    rf_d      = rf_q;
    if (instr_ready) begin
      d_valid_d = instr_valid;
      if (instr_valid) d_instr_d = instr;
    end
    if (!stall) begin
      w_valid_d = d_valid_q;
      if (d_valid_q) begin
        w_rd_d   = rd;
        w_ill_d  = !e_legal;
        w_data_d = e_legal ? e_y : '0;
      end
    end
    if (rf_we) rf_d[w_rd_q[AW-1:0]] = w_data_q;
  end

  // Pipeline and register-file state; reset discards everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_q <= 1'b0;
      d_instr_q <= '0;
      w_valid_q <= 1'b0;
      w_ill_q   <= 1'b0;
      w_rd_q    <= '0;
      w_data_q  <= '0;
      rf_q      <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_instr_q <= d_instr_d;
      w_valid_q <= w_valid_d;
      w_ill_q   <= w_ill_d;
      w_rd_q    <= w_rd_d;
      w_data_q  <= w_data_d;
      rf_q      <= rf_d;
    end
  end

endmodule

// File: tb/tb_rtype_exec_pipe.sv
// Directed bench for rtype_exec_pipe (XLEN=32, default build): expected results
// come from an ISA-level register model and are queued at acceptance, then
// popped and compared when the pipeline retires them.
module tb_rtype_exec_pipe;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam logic [6:0] OP = 7'h33;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [31:0]     instr = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [4:0]      res_rd;
  logic [XLEN-1:0] res_data;
  logic            res_illegal;

  always #5 clk = ~clk;

  rtype_exec_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .res_illegal (res_illegal)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            ill;
  } exp_t;

  exp_t                       sb[$];
  logic [NREGS-1:0][XLEN-1:0] mrf = '0;
  int                         n_cmp = 0;
  int                         n_err = 0;
  logic                       acc = 1'b0;
  logic                       last_vld, last_rdy, last_ill;
  logic [4:0]                 last_rd;
  logic [XLEN-1:0]            last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t            e;
    logic [XLEN-1:0] a, b;
    logic [4:0]      sh;
    a      = mrf[w[19:15]];
    b      = mrf[w[24:20]];
    sh     = b[4:0];
    e.rd   = w[11:7];
    e.data = '0;
    e.ill  = 1'b1;
    if (w[6:0] == OP) begin
      e.ill = 1'b0;
      case ({w[31:25], w[14:12]})
        {7'h00, 3'd0}: e.data = a + b;
        {7'h00, 3'd1}: e.data = a << sh;
        {7'h00, 3'd2}: e.data = {31'b0, $signed(a) < $signed(b)};
        {7'h00, 3'd3}: e.data = {31'b0, a < b};
        {7'h00, 3'd4}: e.data = a ^ b;
        {7'h00, 3'd5}: e.data = a >> sh;
        {7'h00, 3'd6}: e.data = a | b;
        {7'h00, 3'd7}: e.data = a & b;
        {7'h20, 3'd0}: e.data = a - b;
        {7'h20, 3'd5}: e.data = $signed(a) >>> sh;
        default:       e.ill  = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic push_exp(input logic [31:0] w);
    exp_t e;
    e = model(w);
    sb.push_back(e);
    if (!e.ill && e.rd != 5'd0) mrf[e.rd] = e.data;
  endtask

  task automatic check_out();
    exp_t e;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(sb.size()), 64'(1));
      end else begin
        e = sb.pop_front();
        chk("res_rd", 64'(res_rd), 64'(e.rd));
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_illegal", 64'(res_illegal), 64'(e.ill));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    last_vld  = res_valid;
    last_rdy  = instr_ready;
    last_rd   = res_rd;
    last_data = res_data;
    last_ill  = res_illegal;
    check_out();
    acc = instr_valid && instr_ready;
    if (acc) push_exp(instr);
    @(posedge clk);
    #1;
    if (acc) instr_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, output int waits);
    instr       = w;
    instr_valid = 1'b1;
    waits       = 0;
    step();
    while (!acc && waits < 20) begin
      waits++;
      step();
    end
    if (!acc) begin
      chk("send_accept", 64'(acc), 64'(1));
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic apply_seeds();
    force dut.rf_q = mrf;
    @(posedge clk);
    #1;
    release dut.rf_q;
  endtask

  initial begin
    int            w;
    logic [XLEN-1:0] ref_data;
    logic [4:0]      ref_rd;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_rd", 64'(res_rd), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_illegal", 64'(res_illegal), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", 64'(instr_ready), 64'(1));
    @(posedge clk);
    #1;

    // ADD x1,x0,x0 : result visible two cycles after acceptance
    send(enc(7'h00, 3'd0, 5'd1, 5'd0, 5'd0, OP), w);
    step();
    chk("lat_n1_res_valid", 64'(last_vld), 64'(0));
    step();
    chk("lat_n2_res_valid", 64'(last_vld), 64'(1));
    drain();

    // x1=5, then back-to-back ADD x2,x1,x1 / SUB x3,x2,x1 through the W bypass
    mrf[1] = 32'd5;
    apply_seeds();
    send(enc(7'h00, 3'd0, 5'd2, 5'd1, 5'd1, OP), w);
    send(enc(7'h20, 3'd0, 5'd3, 5'd2, 5'd1, OP), w);
    chk("b2b_accept_wait", 64'(w), 64'(0));
    step();
    chk("b2b_first_valid", 64'(last_vld), 64'(1));
    step();
    chk("b2b_second_valid", 64'(last_vld), 64'(1));
    drain();
    send(enc(7'h00, 3'd0, 5'd4, 5'd3, 5'd2, OP), w);
    drain();

    // Shift/compare boundaries
    mrf[5]  = 32'h8000_0000;
    mrf[6]  = 32'd4;
    mrf[7]  = 32'hFFFF_FFFF;
    mrf[8]  = 32'd1;
    mrf[14] = 32'd7;
    mrf[15] = 32'd9;
    apply_seeds();
    send(enc(7'h20, 3'd5, 5'd9,  5'd5, 5'd6, OP), w);
    send(enc(7'h00, 3'd3, 5'd10, 5'd8, 5'd7, OP), w);
    send(enc(7'h00, 3'd2, 5'd11, 5'd8, 5'd7, OP), w);
    send(enc(7'h00, 3'd5, 5'd12, 5'd5, 5'd6, OP), w);
    send(enc(7'h00, 3'd1, 5'd13, 5'd7, 5'd6, OP), w);
    send(enc(7'h00, 3'd4, 5'd16, 5'd5, 5'd7, OP), w);
    send(enc(7'h00, 3'd6, 5'd17, 5'd5, 5'd8, OP), w);
    send(enc(7'h00, 3'd7, 5'd18, 5'd7, 5'd6, OP), w);
    send(enc(7'h00, 3'd2, 5'd19, 5'd7, 5'd8, OP), w);
    drain();

    // Consumer back-pressure with two in the pipe and a third offered
    res_ready = 1'b0;
    send(enc(7'h00, 3'd0, 5'd20, 5'd1, 5'd5, OP), w);
    send(enc(7'h20, 3'd0, 5'd21, 5'd7, 5'd8, OP), w);
    instr       = enc(7'h00, 3'd4, 5'd22, 5'd20, 5'd21, OP);
    instr_valid = 1'b1;
    step();
    chk("stall_instr_ready", 64'(last_rdy), 64'(0));
    chk("stall_res_valid", 64'(last_vld), 64'(1));
    ref_data = last_data;
    ref_rd   = last_rd;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_instr_ready_hold", 64'(last_rdy), 64'(0));
      chk("stall_valid_hold", 64'(last_vld), 64'(1));
      chk("stall_data_hold", 64'(last_data), 64'(ref_data));
      chk("stall_rd_hold", 64'(last_rd), 64'(ref_rd));
    end
    res_ready = 1'b1;
    send(enc(7'h00, 3'd4, 5'd22, 5'd20, 5'd21, OP), w);
    drain();
    step();
    chk("no_duplicate", 64'(last_vld), 64'(0));

    // Illegal words: OP-IMM, funct7=0000001, bad alt pair, word opcode on RV32
    send(enc(7'h09, 3'd0, 5'd14, 5'd1, 5'd3, 7'h13), w);
    send(enc(7'h01, 3'd0, 5'd15, 5'd1, 5'd1, OP), w);
    send(enc(7'h20, 3'd1, 5'd14, 5'd1, 5'd1, OP), w);
    send(enc(7'h00, 3'd0, 5'd15, 5'd1, 5'd1, 7'h3B), w);
    send(enc(7'h00, 3'd0, 5'd16, 5'd14, 5'd15, OP), w);
    send(enc(7'h00, 3'd0, 5'd0,  5'd1, 5'd1, OP), w);
    send(enc(7'h00, 3'd0, 5'd17, 5'd0, 5'd1, OP), w);
    drain();

    // Reset while two instructions are in flight
    send(enc(7'h00, 3'd0, 5'd18, 5'd1, 5'd1, OP), w);
    send(enc(7'h00, 3'd0, 5'd19, 5'd5, 5'd1, OP), w);
    rst = 1'b0;
    sb.delete();
    mrf = '0;
    #2;
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    chk("midrst_res_data", 64'(res_data), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("postrst_res_valid", 64'(last_vld), 64'(0));
    chk("postrst_instr_ready", 64'(last_rdy), 64'(1));
    send(enc(7'h00, 3'd0, 5'd20, 5'd18, 5'd19, OP), w);
    send(enc(7'h00, 3'd6, 5'd21, 5'd1, 5'd5, OP), w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
